hadamard16_seq: RTL
===================

# hadamard16_seq

Frame sequencer for the 16-point Hadamard core (`hadamard16pt`).
- Collects 16 serial signed samples into an input frame buffer, then presents them in parallel to the core.
- Drives the core's `start` enable for exactly the core's pipeline latency, captures the 16 parallel results, and streams them out serially with valid/ready backpressure.
- Sits between the sample stream source and the downstream consumer; the core itself is instantiated beside it and wired via `core_x`/`core_y`/`core_start`.

## Interface
Clocking and reset (decided): one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst_n`.

Parameters:
- `W`, 9 — sample width, signed two's complement; must match the core.
- `N`, 16 — samples per frame; fixed at 16 for this core.
- `LAT`, 4 — core latency in enabled clocks, i.e. number of cycles `start` is held high.

Ports:
- `clk` — input, 1 — rising-edge clock.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `s_valid` — input, 1 — input sample valid.
- `s_ready` — output, 1 — registered; block accepts a sample when `s_valid && s_ready`.
- `s_data` — input, W — signed input sample.
- `s_last` — input, 1 — marks the 16th sample of a frame.
- `m_valid` — output, 1 — output sample valid.
- `m_ready` — input, 1 — downstream accept.
- `m_data` — output, W — signed output sample; y_i in index order 0..15.
- `m_last` — output, 1 — high with y_15.
- `core_start` — output, 1 — drives the core's `start` enable.
- `core_x` — output, N*W — x_i on bits [W*i +: W].
- `core_y` — input, N*W — y_i on bits [W*i +: W].
- `frame_err` — output, 1 — one-cycle pulse on a framing error.
- `busy` — output, 1 — high in any state other than IDLE, or whenever the input buffer is non-empty.

## Operation
- States:
  - IDLE: loading, no output pending.
  - RUN: core enabled.
  - CAP: capture results.
  - DRAIN: streaming results out.
- Input buffer:
  - 16 x W registers plus `in_cnt` (0..16).
  - An accepted sample is written to slot `in_cnt`; `in_cnt` then increments.
  - `core_x` is driven continuously from this buffer.
- `s_ready` = 1 only when next state is IDLE or DRAIN and the buffer is not full (`in_cnt` < 16).
  - Forced to 0 in RUN and CAP, so `core_x` is stable while the core computes.
- Framing error: `s_last` = 1 on a slot other than 15, or `s_last` = 0 on slot 15.
  - The sample is consumed.
  - `in_cnt` returns to 0; the partial frame is discarded.
  - `frame_err` pulses for 1 cycle.
  - No transition to RUN.
- Transitions:
  - IDLE -> RUN when the 16th sample is accepted without error.
  - RUN:
    - `core_start` = 1.
    - `run_cnt` counts 0..LAT-1.
    - At `run_cnt` = LAT-1 -> CAP.
  - CAP:
    - `core_start` = 0.
    - The core holds its outputs; all 16 `core_y` words are copied into the output buffer.
    - `in_cnt` is cleared (input buffer freed).
    - -> DRAIN.
  - DRAIN:
    - `m_valid` = 1.
    - `m_data` = output buffer[`out_idx`].
    - `out_idx` advances on each `m_valid && m_ready`.
    - `m_last` = (`out_idx` == 15).
    - After the y_15 handshake: -> RUN if the input buffer is full, otherwise -> IDLE.
    - `out_idx` wraps to 0.
- Overlap: during DRAIN the next frame may load; its completion does not leave DRAIN early.
- Arithmetic: none in this block. Core results are passed bit-exact; the core wraps modulo 2^W.

## Timing
- Reset values (asynchronous, all outputs, counters and buffers):
  - state = IDLE.
  - `s_ready` = 0; rises at the first `clk` edge after `rst_n` release.
  - `m_valid` = 0, `m_last` = 0, `core_start` = 0, `frame_err` = 0, `busy` = 0.
  - `core_x` = 0, `m_data` = 0.
- Latency, taking the 16th-sample handshake cycle as cycle 0:
  - `core_start` = 1 in cycles 1..LAT.
  - CAP in cycle LAT+1.
  - `m_valid` first high in cycle LAT+2 (6 at LAT = 4).
- Throughput:
  - 1 sample per cycle in and out when `m_ready` is held at 1.
  - Back-to-back full frames: 16 + LAT + 1 cycles per frame after the first.
- `m_data`/`m_last` hold stable while `m_valid && !m_ready`.
- Reset mid-frame:
  - Everything clears asynchronously and `core_start` drops immediately.
  - No partial output.
  - The first frame after reset is fully correct; stale core contents are overwritten by the LAT enabled cycles.
- Simultaneous y_15 handshake and 16th-input handshake in the same cycle: next state is RUN.

## Test plan
- Impulse: x0 = 1, others 0, `m_ready` = 1 -> `m_valid` rises 6 cycles after the `s_last` handshake; all 16 outputs = 1; `m_last` only on the 16th.
- DC: all x = 1 -> y0 = 16, y1..y15 = 0.
- Overflow wrap: all x = 31 -> y0 = -16 (496 mod 512, as 9-bit signed); others 0.
- Backpressure: `m_ready` toggled 1,0,0,1,... during DRAIN while the next frame loads -> no output lost or duplicated; `s_ready` = 0 once 16 new samples are buffered; the second frame's results are correct and start with RUN immediately after the first frame's y_15 handshake.
- Framing error: `s_last` on sample 9 -> `frame_err` 1-cycle pulse, no `core_start`; the following clean 16-sample frame is processed normally.
- Reset in RUN: `rst_n` low during cycle 2 of RUN -> `core_start`, `m_valid` and `s_ready` go to 0 at once; after release, a new impulse frame yields all outputs = 1.

Source files
------------

// File: rtl/hadamard16_seq_if.sv
// -----------------------------------------------------------------------------
// hadamard16_seq_if
// Signal bundle between the frame sequencer, its sample source, its result
// consumer and the 16-point Hadamard core placed beside it.
//
// Signals:
//   s_valid/s_ready/s_data/s_last : serial input sample stream (s_last marks x15)
//   m_valid/m_ready/m_data/m_last : serial output result stream (m_last marks y15)
//   core_start                    : enable for the Hadamard core pipeline
//   core_x                        : parallel frame to the core, x_i at [W*i +: W]
//   core_y                        : parallel results from the core, y_i at [W*i +: W]
//   frame_err                     : one-cycle pulse on a framing error
//   busy                          : sequencer not idle or input buffer non-empty
//
// Modports:
//   slave  : the sequencer itself
//   master : the environment (source, sink and core)
// -----------------------------------------------------------------------------
interface hadamard16_seq_if #(
  parameter int W = 9,
  parameter int N = 16
);
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           s_last;

  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;

  logic           core_start;
  logic [N*W-1:0] core_x;
  logic [N*W-1:0] core_y;

  logic           frame_err;
  logic           busy;

  modport slave (
    input  s_valid, s_data, s_last, m_ready, core_y,
    output s_ready, m_valid, m_data, m_last, core_start, core_x, frame_err, busy
  );

  modport master (
    output s_valid, s_data, s_last, m_ready, core_y,
    input  s_ready, m_valid, m_data, m_last, core_start, core_x, frame_err, busy
  );
endinterface

// File: rtl/hadamard16_seq.sv
// -----------------------------------------------------------------------------
// hadamard16_seq
// Frame sequencer for the 16-point Hadamard core. Gathers 16 serial signed
// samples into an input buffer, holds them on core_x while the core is enabled
// for LAT cycles, copies the 16 core results into an output buffer and streams
// them out serially with valid/ready flow control. The next frame may load
// while the previous one drains.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hadamard16_seq_if.slave (sample stream in, result stream out,
//           core_start/core_x/core_y to the core, frame_err, busy)
//
// Parameters:
//   W   : sample width (signed two's complement), must match the core
//   N   : samples per frame (16 for this core)
//   LAT : core latency in enabled cycles (cycles core_start is held high)
// -----------------------------------------------------------------------------
module hadamard16_seq #(
  parameter int W   = 9,
  parameter int N   = 16,
  parameter int LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  hadamard16_seq_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);
  localparam int RUN_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CAP   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             frame_err_q;

  logic [W-1:0]     in_buf_q  [N];
  logic [W-1:0]     out_buf_q [N];
  logic [N*W-1:0]   core_x_w;

  logic             s_fire;
  logic             s_slot_last;
  logic             s_err;
  logic             s_ok;
  logic             m_fire;

  // Input handshake decode. A framing error is any mismatch between s_last
  // and the slot being written: the sample is swallowed and the frame dropped.
  assign s_fire      = bus.s_valid & s_ready_q;
  assign s_slot_last = (in_cnt_q == CNT_LAST);
  assign s_err       = s_fire & (bus.s_last ^ s_slot_last);
  assign s_ok        = s_fire & ~s_err;
  assign m_fire      = (state_q == DRAIN) & bus.m_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (s_ok && s_slot_last) state_d = RUN;
      end
      RUN: begin
        if (run_cnt_q == RUN_LAST) state_d = CAP;
      end
      CAP: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // A frame that completed during the drain (or on this very cycle)
        // goes straight into the core after y15 leaves.
        if (m_fire && (out_idx_q == IDX_LAST)) begin
          state_d = (in_cnt_d == CNT_FULL) ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.core_start = (state_q == RUN);
    bus.m_valid    = (state_q == DRAIN);
    bus.m_last     = (state_q == DRAIN) && (out_idx_q == IDX_LAST);
    bus.m_data     = out_buf_q[out_idx_q];
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE) || (in_cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Counters and s_ready next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_cnt_d = in_cnt_q;
    if ((state_q == CAP) || s_err) begin
      in_cnt_d = '0;
    end else if (s_ok) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
    end

    out_idx_d = out_idx_q;
    if (m_fire) begin
      out_idx_d = (out_idx_q == IDX_LAST) ? '0 : out_idx_q + IDX_W'(1);
    end

    run_cnt_d = '0;
    if ((state_q == RUN) && (run_cnt_q != RUN_LAST)) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end

    // Registered ready looks at the coming state so core_x is frozen for the
    // whole of RUN and CAP, and a full buffer stalls the source.
    s_ready_d = ((state_d == IDLE) || (state_d == DRAIN)) && (in_cnt_d < CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q    <= '0;
      out_idx_q   <= '0;
      run_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      out_idx_q   <= out_idx_d;
      run_cnt_q   <= run_cnt_d;
      s_ready_q   <= s_ready_d;
      frame_err_q <= s_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame buffers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        in_buf_q[i]  <= '0;
        out_buf_q[i] <= '0;
      end
    end else begin
      // s_ok only occurs with in_cnt_q below N, so the low bits address a slot.
      if (s_ok) begin
        in_buf_q[in_cnt_q[IDX_W-1:0]] <= bus.s_data;
      end
      // The core holds its results once start drops, so one copy is enough.
      if (state_q == CAP) begin
        for (int i = 0; i < N; i++) begin
          out_buf_q[i] <= bus.core_y[W*i +: W];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_core_x
    assign core_x_w[W*gi +: W] = in_buf_q[gi];
  end

  assign bus.core_x = core_x_w;

endmodule
